// File: rtl/fifo_uart_pkg.sv
// Shared encodings for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// Bit-period counter: bit_end pulses on the last cycle of each CLKS_PER_BIT window.
// clear restarts the window so every state begins on a fresh bit boundary.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter popping one byte per frame from a FIFO read port.
// First start-bit cycle 3 cycles after the IDLE decision; stalls in IDLE while empty or disabled.
module fifo_uart_tx import fifo_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              tx_n;
  logic              bit_end;
  logic              clear;

  // Restarting the timer on every state change aligns bit periods to state entry.
  assign clear = (state_n != state);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      idx     <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      idx     <= idx_n;
      tx      <= tx_n;
      tx_done <= (state == STOP) && bit_end;
    end
  end

  // tx_n is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_n = FETCH;
      end
      FETCH: begin
        state_n = LOAD;
      end
      LOAD: begin
        shift_n = fifo_dout;
        idx_n   = '0;
        tx_n    = 1'b0;
        state_n = START;
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          tx_n    = shift[0];
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end) begin
          if (idx == LAST_IDX) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift >> 1;
            idx_n   = idx + 1'b1;
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign fifo_rd_en = (state == FETCH);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (4 and 2 clocks per bit) fed by behavioural FIFOs.
module tb_fifo_uart_tx;

  localparam int CPB0 = 4;
  localparam int CPB1 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty [2] = '{1'b1, 1'b1};
  logic [7:0] fifo_dout  [2] = '{8'h00, 8'h00};
  logic       fifo_rd_en [2];
  logic       tx         [2];
  logic       busy       [2];
  logic       tx_done    [2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB0), .DATA_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]),
    .fifo_dout(fifo_dout[0]), .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]),
    .busy(busy[0]), .tx_done(tx_done[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB1), .DATA_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]),
    .fifo_dout(fifo_dout[1]), .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]),
    .busy(busy[1]), .tx_done(tx_done[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int cpb(input int s);
    return (s == 0) ? CPB0 : CPB1;
  endfunction

  // FIFO model and line decoder, both evaluated on the falling edge.
  logic [7:0] fq      [2][$];
  logic [7:0] rx      [2][$];
  int         start_t [2][$];
  int         pops    [2] = '{0, 0};
  logic       prev_rd [2] = '{1'b0, 1'b0};
  logic       prev_tx [2] = '{1'b1, 1'b1};
  logic       in_fr   [2] = '{1'b0, 1'b0};
  int         dcnt    [2] = '{0, 0};
  logic [7:0] dsh     [2] = '{8'h00, 8'h00};
  int         cyc = 0, bad_pop = 0, dbl_pop = 0, frame_err = 0;

  always @(negedge clk) begin
    cyc++;
    for (int s = 0; s < 2; s++) begin
      if (fifo_rd_en[s] === 1'b1) begin
        if (fq[s].size() == 0) bad_pop++;
        else fifo_dout[s] = fq[s].pop_front();
        pops[s]++;
        if (prev_rd[s] === 1'b1) dbl_pop++;
      end
      prev_rd[s]    = fifo_rd_en[s];
      fifo_empty[s] = (fq[s].size() == 0);
      if (rst === 1'b1) begin
        in_fr[s] = 1'b0;
      end else if (!in_fr[s]) begin
        if (prev_tx[s] === 1'b1 && tx[s] === 1'b0) begin
          in_fr[s] = 1'b1;
          dcnt[s]  = 0;
          start_t[s].push_back(cyc);
        end
      end else begin
        int c, k;
        dcnt[s]++;
        c = cpb(s);
        k = dcnt[s] / c;
        if (dcnt[s] % c == c / 2) begin
          if (k >= 1 && k <= 8) dsh[s][k-1] = tx[s];
          if (k == 9) begin
            if (tx[s] !== 1'b1) frame_err++;
            rx[s].push_back(dsh[s]);
            in_fr[s] = 1'b0;
          end
        end
      end
      prev_tx[s] = tx[s];
    end
  end

  task automatic wait_pop(input int s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fifo_rd_en[s] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int s, input int target, input int budget);
    for (int i = 0; i < budget && rx[s].size() < target; i++) @(negedge clk);
  endtask

  // One frame from idle, checked cycle by cycle against a hand-written line pattern.
  task automatic run_frame(input int s, input logic [7:0] data, input logic [9:0] frame);
    bit ok;
    int p0, r0;
    p0 = pops[s];
    r0 = rx[s].size();
    fq[s].push_back(data);
    wait_pop(s, ok);
    check("pop_seen", 32'(ok), 1);
    check("busy_in_fetch", 32'(busy[s]), 1);
    @(negedge clk);
    check("rd_single_cycle", 32'(fifo_rd_en[s]), 0);
    check("tx_high_in_load", 32'(tx[s]), 1);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < cpb(s); c++) begin
        @(negedge clk);
        if (tx[s] !== frame[i]) begin
          n_bad++;
          $display("FAIL line_bit%0d_cyc%0d dut%0d: got %b, expected %b", i, c, s, tx[s], frame[i]);
        end
        n_vec++;
      end
    end
    @(negedge clk);
    check("tx_done_pulse", 32'(tx_done[s]), 1);
    check("busy_low_after", 32'(busy[s]), 0);
    @(negedge clk);
    check("tx_done_one_cycle", 32'(tx_done[s]), 0);
    check("pops_per_frame", 32'(pops[s] - p0), 1);
    check("rx_count", 32'(rx[s].size() - r0), 1);
    if (rx[s].size() > r0) check("rx_byte", 32'(rx[s][r0]), 32'(data));
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  initial begin
    vec_t vecs[5];
    bit   ok;
    int   viol, p0, r0, sb;

    // frame bit i is the line during bit period i: start, d0..d7, stop
    vecs[0] = '{0, 8'hA5, 10'b1101001010};
    vecs[1] = '{0, 8'h81, 10'b1100000010};
    vecs[2] = '{1, 8'hFF, 10'b1111111110};
    vecs[3] = '{1, 8'h00, 10'b1000000000};
    vecs[4] = '{1, 8'hA5, 10'b1101001010};

    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_tx", 32'(tx[s]), 1);
      check("rst_busy", 32'(busy[s]), 0);
      check("rst_rd_en", 32'(fifo_rd_en[s]), 0);
      check("rst_tx_done", 32'(tx_done[s]), 0);
    end
    rst    = 1'b0;
    enable = 1'b1;
    viol   = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_rd_en[0] !== 1'b0) viol++;
    end
    check("idle_quiet_when_empty", 32'(viol), 0);

    for (int v = 0; v < 5; v++) run_frame(vecs[v].sel, vecs[v].data, vecs[v].frame);

    // enable low holds off a non-empty FIFO, then a preloaded burst drains
    enable = 1'b0;
    p0 = pops[0];
    r0 = rx[0].size();
    sb = start_t[0].size();
    for (int i = 1; i <= 10; i++) fq[0].push_back(8'(i));
    repeat (20) @(negedge clk);
    check("no_pop_enable_low", 32'(pops[0] - p0), 0);
    enable = 1'b1;
    wait_rx(0, r0 + 10, 600);
    check("burst_frames", 32'(rx[0].size() - r0), 10);
    check("burst_pops", 32'(pops[0] - p0), 10);
    if (rx[0].size() >= r0 + 10) begin
      for (int i = 0; i < 10; i++) check("burst_byte", 32'(rx[0][r0+i]), 32'(i + 1));
      for (int i = 0; i < 9; i++)
        check("burst_spacing", 32'(start_t[0][sb+i+1] - start_t[0][sb+i]), 43);
    end

    // enable dropped mid-frame: current frame finishes, nothing further popped
    p0 = pops[0];
    r0 = rx[0].size();
    fq[0].push_back(8'h3C);
    wait_pop(0, ok);
    check("drop_pop_seen", 32'(ok), 1);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    fq[0].push_back(8'h55);
    repeat (60) @(negedge clk);
    check("drop_pops", 32'(pops[0] - p0), 1);
    check("drop_frames", 32'(rx[0].size() - r0), 1);
    if (rx[0].size() > r0) check("drop_byte", 32'(rx[0][r0]), 32'h3C);
    enable = 1'b1;
    wait_rx(0, r0 + 2, 80);
    if (rx[0].size() > r0 + 1) check("resume_byte", 32'(rx[0][r0+1]), 32'h55);
    else check("resume_frames", 32'(rx[0].size() - r0), 2);

    // byte arriving during STOP is fetched straight out of the tx_done cycle
    wait_rx(0, r0 + 2, 1);
    repeat (4) @(negedge clk);
    r0 = rx[0].size();
    fq[0].push_back(8'h11);
    wait_pop(0, ok);
    check("stop_pop_seen", 32'(ok), 1);
    repeat (39) @(negedge clk);
    fq[0].push_back(8'h22);
    repeat (3) @(negedge clk);
    check("stop_done_cycle", 32'(tx_done[0]), 1);
    check("stop_no_pop_in_done", 32'(fifo_rd_en[0]), 0);
    @(negedge clk);
    check("stop_fetch_next", 32'(fifo_rd_en[0]), 1);
    wait_rx(0, r0 + 2, 80);
    check("stop_frames", 32'(rx[0].size() - r0), 2);
    if (rx[0].size() > r0 + 1) begin
      check("stop_byte1", 32'(rx[0][r0]), 32'h11);
      check("stop_byte2", 32'(rx[0][r0+1]), 32'h22);
    end

    // reset asserted mid-DATA forces the line high before the next clock edge
    repeat (4) @(negedge clk);
    fq[0].push_back(8'h00);
    wait_pop(0, ok);
    check("rst_mid_pop_seen", 32'(ok), 1);
    repeat (8) @(negedge clk);
    check("pre_reset_data_low", 32'(tx[0]), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx[0]), 1);
    check("async_rst_busy", 32'(busy[0]), 0);
    check("async_rst_rd_en", 32'(fifo_rd_en[0]), 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    p0   = pops[0];
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
    end
    check("after_rst_idle", 32'(viol), 0);
    check("after_rst_no_pop", 32'(pops[0] - p0), 0);

    check("pop_while_empty", 32'(bad_pop), 0);
    check("back_to_back_pops", 32'(dbl_pop), 0);
    check("stop_bit_errors", 32'(frame_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
